// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD command sequencer: command codes, idle code
// and classification helpers used by the FIFO front end and issue FSM.
package lcd_pkg;

    typedef enum logic [3:0] {
        CmdWrite = 4'd0,
        CmdUp    = 4'd1,
        CmdDown  = 4'd2,
        CmdLeft  = 4'd3,
        CmdRight = 4'd4,
        CmdMax   = 4'd5,
        CmdMin   = 4'd6,
        CmdAvg   = 4'd7,
        CmdCcw   = 4'd8,
        CmdCw    = 4'd9,
        CmdMirx  = 4'd10,
        CmdMiry  = 4'd11
    } lcd_cmd_e;

    // Code presented to the controller whenever no command is active.
    localparam logic [3:0] LcdNopCmd = 4'hC;

    function automatic logic is_shift(input logic [3:0] code);
        return (code >= 4'd1) && (code <= 4'd4);
    endfunction

    function automatic logic is_block(input logic [3:0] code);
        return (code >= 4'd5) && (code <= 4'd11);
    endfunction

endpackage

// File: rtl/lcd_cmd_fifo.sv
// Synchronous Depth x 4-bit command FIFO with first-word-fall-through read
// data and an occupancy count.
//   clk_i, rst_ni : clock, async active-low reset (empties the FIFO)
//   push_i/wdata_i: write one entry (caller guarantees not full)
//   pop_i/rdata_o : rdata_o shows the head; pop_i drops it (caller guarantees not empty)
//   empty_o       : no entries held
//   count_o       : number of entries held, 0..Depth
module lcd_cmd_fifo #(
    parameter int unsigned Depth = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  logic [3:0]               wdata_i,
    input  logic                     pop_i,
    output logic [3:0]               rdata_o,
    output logic                     empty_o,
    output logic [$clog2(Depth):0]   count_o
);

    localparam int unsigned Aw   = $clog2(Depth);
    localparam int unsigned CntW = Aw + 1;

    logic [3:0]      mem_q [Depth];
    logic [Aw-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0] count_q, count_d;

    // Depth is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + Aw'(1);
            if (pop_i)  rd_ptr_q <= rd_ptr_q + Aw'(1);
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i) mem_q[wr_ptr_q] <= wdata_i;
    end

    always_comb begin
        count_d = count_q;
        unique case ({push_i, pop_i})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

endmodule

// File: rtl/lcd_cmd_sequencer.sv
// Queues host commands and issues them one at a time to the LCD image
// controller, hiding its level-sampled command semantics behind a
// valid/ready push port.
// Build option: define LCD_SEQ_FILTER_EN to drop codes 12-15 at the push
// port and flag them on cmd_err_o; otherwise they are issued as block ops.
//   clk_i, rst_ni           : clock, async active-low reset
//   host_cmd_i/host_valid_i : host command push; host_ready_o = space and not finished
//   lcd_cmd_o               : command level to the controller (NopCmd when idle)
//   lcd_cmd_valid_o         : one-cycle pulse at issue
//   lcd_busy_i, lcd_done_i  : controller busy and write-out complete
//   fifo_count_o            : entries queued
//   seq_done_o              : write-out finished, sticky until reset
//   cmd_err_o               : sticky illegal-command flag (filter builds only)
module lcd_cmd_sequencer
    import lcd_pkg::*;
#(
    parameter int unsigned Depth    = 8,
    parameter int unsigned GuardCyc = 2,
    parameter logic [3:0]  NopCmd   = LcdNopCmd
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [3:0]             host_cmd_i,
    input  logic                   host_valid_i,
    output logic                   host_ready_o,
    output logic [3:0]             lcd_cmd_o,
    output logic                   lcd_cmd_valid_o,
    input  logic                   lcd_busy_i,
    input  logic                   lcd_done_i,
    output logic [$clog2(Depth):0] fifo_count_o,
    output logic                   seq_done_o,
    output logic                   cmd_err_o
);

    localparam int unsigned   CntW    = $clog2(Depth) + 1;
    localparam logic [CntW-1:0] FullCnt = CntW'(Depth);

    typedef enum logic [2:0] {
        StIdle, StIssue, StGuard, StWait, StFlush, StDone
    } state_e;

    state_e     state_q, state_d;
    logic [3:0] cmd_q, cmd_d;
    logic [1:0] guard_q, guard_d;
    logic       accept, push, pop, fifo_empty;
    logic [3:0] head;

    assign host_ready_o = (fifo_count_o < FullCnt) && (state_q != StDone);
    assign accept       = host_valid_i && host_ready_o;

`ifdef LCD_SEQ_FILTER_EN
    logic illegal, cmd_err_q;
    assign illegal = !is_shift(host_cmd_i) && !is_block(host_cmd_i) &&
                     (host_cmd_i != CmdWrite);
    // Illegal codes still complete the handshake so the host never stalls.
    assign push = accept && !illegal;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) cmd_err_q <= 1'b0;
        else if (accept && illegal) cmd_err_q <= 1'b1;
    end
    assign cmd_err_o = cmd_err_q;
`else
    assign push      = accept;
    assign cmd_err_o = 1'b0;
`endif

    lcd_cmd_fifo #(
        .Depth (Depth)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (push),
        .wdata_i (host_cmd_i),
        .pop_i   (pop),
        .rdata_o (head),
        .empty_o (fifo_empty),
        .count_o (fifo_count_o)
    );

    // cmd_q resets asynchronously, so lcd_cmd_o drops to NopCmd with reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            cmd_q   <= NopCmd;
            guard_q <= '0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            guard_q <= guard_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        guard_d = guard_q;
        pop     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!fifo_empty && !lcd_busy_i) begin
                    pop     = 1'b1;
                    cmd_d   = head;
                    state_d = StIssue;
                end
            end
            StIssue: begin
                if (cmd_q == CmdWrite) begin
                    state_d = StFlush;
                end else if (is_shift(cmd_q)) begin
                    // Shifts act on every sampled cycle, so hold for one only.
                    cmd_d   = NopCmd;
                    state_d = StIdle;
                end else begin
                    guard_d = '0;
                    state_d = StGuard;
                end
            end
            StGuard: begin
                // Give the controller time to raise busy before trusting it.
                if (guard_q == 2'(GuardCyc - 1)) state_d = StWait;
                else guard_d = guard_q + 2'd1;
            end
            StWait: begin
                if (!lcd_busy_i) begin
                    cmd_d   = NopCmd;
                    state_d = StIdle;
                end
            end
            StFlush: begin
                if (lcd_done_i) begin
                    cmd_d   = NopCmd;
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StDone;
            end
            default: begin
                cmd_d   = NopCmd;
                state_d = StIdle;
            end
        endcase
    end

    assign lcd_cmd_o       = cmd_q;
    assign lcd_cmd_valid_o = (state_q == StIssue);
    assign seq_done_o      = (state_q == StDone);

endmodule

// File: doc/lcd_cmd_sequencer.md
# lcd_cmd_sequencer

- Buffers image-processing commands from a host in a small FIFO and issues them one at a time to the LCD image controller (8×8 pixel buffer with load/process/write phases) over its `cmd`/`cmd_valid`/`busy`/`done` interface.
- Hides the controller's level-sampled command semantics from the host, which only sees a valid/ready push interface.
- Sits between the testbench/host command source and the LCD controller.

## Interface
- DEPTH, 8: command FIFO entries (power of 2, ≥2).
- GUARD_CYC, 2: cycles to wait after issue before sampling `lcd_busy` (1–3).
- NOP_CMD, 4'hC: code driven on `lcd_cmd` when no command is active.
- clk  in  1  clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- host_cmd  in  4  command code (0 = write-out, 1–4 = shift, 5–11 = block ops).
- host_valid  in  1  `host_cmd` valid.
- host_ready  out  1  FIFO can accept this cycle.
- lcd_cmd  out  4  command level to the LCD controller.
- lcd_cmd_valid  out  1  one-cycle pulse at command issue.
- lcd_busy  in  1  LCD controller busy.
- lcd_done  in  1  LCD controller write-out complete.
- fifo_count  out  $clog2(DEPTH)+1  entries held.
- seq_done  out  1  sequence finished; sticky until reset.
- cmd_err  out  1  sticky illegal-command flag.

## Operation
- Push occurs when `host_valid && host_ready`.
- `host_ready = (fifo_count < DEPTH) && state != DONE` (combinational).
- States:
  - IDLE: if FIFO non-empty and `lcd_busy == 0`, pop the head → ISSUE.
  - ISSUE (1 cycle): `lcd_cmd` = popped code, `lcd_cmd_valid = 1`.
    - Code 1–4 → IDLE, `lcd_cmd` returns to NOP_CMD next cycle. A shift code is never presented for more than 1 cycle.
    - Code 5–11 → GUARD.
    - Code 0 → FLUSH.
  - GUARD: counts GUARD_CYC cycles with `lcd_cmd` held → WAIT.
  - WAIT: hold `lcd_cmd` until `lcd_busy == 0`, then `lcd_cmd` = NOP_CMD → IDLE.
  - FLUSH: hold code 0 until `lcd_done == 1` → DONE.
  - DONE: `seq_done = 1`, `lcd_cmd = NOP_CMD`, no pops or pushes. Exits only via reset.
- Simultaneous push and pop: `fifo_count` unchanged; head and tail pointers both advance.
- Push while full cannot occur, because `host_ready` is low.
- Pointers wrap modulo DEPTH.
- Commands left in the FIFO after code 0 are discarded; `fifo_count` keeps its value in DONE.
- Reset mid-operation:
  - FIFO is emptied and state goes to IDLE.
  - `lcd_cmd` becomes NOP_CMD immediately (asynchronously); any in-flight command is abandoned.

## Timing
- Reset values:
  - `lcd_cmd = NOP_CMD`; `lcd_cmd_valid`, `seq_done`, `cmd_err` = 0; `fifo_count = 0`.
  - `host_ready = 1` once reset deasserts.
- Latency to issue: a push into an empty FIFO with `lcd_busy` low gives `lcd_cmd_valid` 2 edges later (push edge, then IDLE → ISSUE edge).
- Shift commands: back-to-back issues are at minimum 2 cycles apart (ISSUE, IDLE).
- Block commands: ISSUE, then GUARD_CYC cycles, then WAIT. The earliest next issue is 1 cycle after `lcd_busy` is sampled low in WAIT.
- `lcd_busy` high while in IDLE (e.g. during the initial image load) blocks issue indefinitely.
- `seq_done` rises on the edge after `lcd_done` is sampled high in FLUSH.

## Configuration
- `LCD_SEQ_FILTER_EN` defined:
  - Pushes with code 12–15 are accepted (handshake completes) but not written to the FIFO.
  - `cmd_err` is set and stays set until reset.
- `LCD_SEQ_FILTER_EN` undefined:
  - Codes 12–15 are queued and issued like block commands (ISSUE/GUARD/WAIT).
  - `cmd_err` is tied 0.

## Structure
- Shared package `lcd_pkg`: 4-bit command enum (WRITE=0, UP, DOWN, LEFT, RIGHT, MAX, MIN, AVG, CCW, CW, MIRX, MIRY), NOP code, and the `is_shift` and `is_block` helper functions.
- One natural sub-module: `lcd_cmd_fifo`, a synchronous DEPTH×4 FIFO with count output and async active-low reset.
- The FSM and command hold logic live in the top module.

## Test plan
- Push UP, RIGHT with `lcd_busy` low:
  - `lcd_cmd` = 1 for exactly 1 cycle, then NOP_CMD, then 4 for 1 cycle.
  - Two `lcd_cmd_valid` pulses, 2 cycles apart.
- Push MAX (5); model raises `lcd_busy` for 4 cycles starting 1 cycle after issue:
  - `lcd_cmd` holds 5 until busy falls, then NOP_CMD.
  - Next queued command issues on the following cycle.
- Push 9 commands with `lcd_busy` held high:
  - `host_ready` drops after the 8th push; `fifo_count` = 8.
  - Releasing busy drains all 8 in order.
- Push AVG, WRITE (0), MIRX:
  - After 0, FSM waits in FLUSH; `lcd_done` pulse gives `seq_done` = 1 next edge.
  - MIRX is never issued; `host_ready` = 0.
- With `LCD_SEQ_FILTER_EN`, push 14 then UP:
  - `cmd_err` = 1, `fifo_count` increments once, only UP is issued.
- Assert reset while in WAIT with 3 entries queued:
  - `lcd_cmd` = NOP_CMD immediately, `fifo_count` = 0.
  - After release, `host_ready` = 1 and there is no residual issue.
